// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter: source
// indices, default widths and the result record type.
package wb_arbiter_pkg;

  localparam int NUM_WB_SRC = 4;
  localparam int WB_DATA_W  = 32;
  localparam int WB_RD_W    = 5;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_MUL = 2;
  localparam int WB_SRC_DIV = 3;

  typedef struct packed {
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching from rr_ptr+1 with wrap.
// rr_ptr holds the last granted index and is the only state.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cand;

  always_comb begin
    grant   = '0;
    gnt_idx = rr_ptr;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // Reset to the last index so source 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= PW'(N - 1);
    else if (gnt_any) rr_ptr <= gnt_idx;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: each execute pipe has a one-entry holding slot that
// bypasses when empty; a round-robin grant feeds the registered wr_* port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_WB_SRC,
  parameter int DATA_W  = WB_DATA_W,
  parameter int RD_W    = WB_RD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*RD_W-1:0]   src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      wr_en,
  output logic [RD_W-1:0]           wr_rd,
  output logic [DATA_W-1:0]         wr_data,
  output logic [1:0]                wr_src,
  output logic                      busy
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Handshake: a result transfers on a cycle where src_valid & src_ready.
  // A source must hold valid/rd/data stable while valid & ~ready.
  logic [NUM_SRC-1:0] slot_valid;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] load;
  logic [RD_W-1:0]    slot_rd   [NUM_SRC];
  logic [DATA_W-1:0]  slot_data [NUM_SRC];
  logic [RD_W-1:0]    cand_rd   [NUM_SRC];
  logic [DATA_W-1:0]  cand_data [NUM_SRC];
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_rd[i]   = slot_valid[i] ? slot_rd[i]   : src_rd[i*RD_W +: RD_W];
      cand_data[i] = slot_valid[i] ? slot_data[i] : src_data[i*DATA_W +: DATA_W];
    end
  end

  assign req       = slot_valid | src_valid;
  assign src_ready = ~slot_valid | grant;
  // Accepted input goes to the slot unless it was itself the bypass winner.
  assign load      = src_valid & src_ready & (slot_valid | ~grant);
  assign busy      = |slot_valid;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (load[i]) begin
          slot_valid[i] <= 1'b1;
          slot_rd[i]    <= src_rd[i*RD_W +: RD_W];
          slot_data[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Writes to x0 still consume the grant but never assert wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_rd   <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else if (gnt_any) begin
      wr_en   <= |cand_rd[gnt_idx];
      wr_rd   <= cand_rd[gnt_idx];
      wr_data <= cand_data[gnt_idx];
      wr_src  <= 2'(gnt_idx);
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: uncontended vector table, then hand-written
// collision, fairness, back-pressure and mid-operation reset sequences.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N  = NUM_WB_SRC;
  localparam int RW = WB_RD_W;
  localparam int DW = WB_DATA_W;
  localparam int W  = 2 + RW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_ready;
  logic [N*RW-1:0] src_rd = '0;
  logic [N*DW-1:0] src_data = '0;
  logic            wr_en;
  logic [RW-1:0]   wr_rd;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_src;
  logic            busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int wr_cnt[N];

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .wr_en     (wr_en),
    .wr_rd     (wr_rd),
    .wr_data   (wr_data),
    .wr_src    (wr_src),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    src_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic set_src(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] data);
    src_rd[i*RW +: RW]   = rd;
    src_data[i*DW +: DW] = data;
  endtask

  task automatic expect_wr(input int s, input logic [RW-1:0] rd, input logic [DW-1:0] data);
    logic [1:0] s2;
    s2 = 2'(s);
    exp_q.push_back({s2, rd, data});
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (wr_en === 1'b1) begin
      wr_cnt[wr_src]++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got src=%0d rd=%0d data=0x%0h, expected no write",
                 wr_src, wr_rd, wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_seq", {wr_src, wr_rd, wr_data}, e);
      end
    end
  end

  // Source protocol: a stalled source must hold its request unchanged.
  logic [N-1:0]    stall_q = '0;
  logic [N*RW-1:0] rd_q;
  logic [N*DW-1:0] data_q;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && stall_q[i] && (!src_valid[i] || src_rd[i*RW +: RW] !== rd_q[i*RW +: RW] ||
          src_data[i*DW +: DW] !== data_q[i*DW +: DW]))
        $error("source %0d changed its request while stalled", i);
    end
    stall_q <= rst ? '0 : (src_valid & ~src_ready);
    rd_q    <= src_rd;
    data_q  <= src_data;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    int            src;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          exp_en;
  } vec_t;

  function automatic logic [RW-1:0] fr_rd(input int i, input int r);
    return RW'(1 + i * 4 + r);
  endfunction

  function automatic logic [DW-1:0] fr_data(input int i, input int r);
    return 32'hA000_0000 | DW'(i << 8) | DW'(r);
  endfunction

  initial begin
    vec_t vecs[4];
    int cnt[N];
    logic [N-1:0] acc;

    vecs[0] = '{0, 5'd5,  32'hDEAD_BEEF, 1'b1};
    vecs[1] = '{3, 5'd0,  32'h0000_0055, 1'b0};
    vecs[2] = '{2, 5'd31, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1, 5'd17, 32'h0000_0000, 1'b1};

    @(negedge clk);
    do_reset();
    check("reset_wr_en",   wr_en,   0);
    check("reset_wr_rd",   wr_rd,   0);
    check("reset_wr_data", wr_data, 0);
    check("reset_wr_src",  wr_src,  0);
    check("reset_busy",    busy,    0);
    check("reset_rr_ptr",  dut.u_arb.rr_ptr, 3);

    // Uncontended single-source writes, including an x0 result.
    foreach (vecs[v]) begin
      src_valid = '0;
      set_src(vecs[v].src, vecs[v].rd, vecs[v].data);
      src_valid[vecs[v].src] = 1'b1;
      if (vecs[v].exp_en) expect_wr(vecs[v].src, vecs[v].rd, vecs[v].data);
      #1;
      check("vec_ready", src_ready, 4'b1111);
      tick();
      src_valid = '0;
      check("vec_wr_en",   wr_en,   vecs[v].exp_en);
      check("vec_wr_rd",   wr_rd,   vecs[v].rd);
      check("vec_wr_data", wr_data, vecs[v].data);
      check("vec_wr_src",  wr_src,  vecs[v].src);
      check("vec_busy",    busy,    0);
      check("vec_rr_ptr",  dut.u_arb.rr_ptr, vecs[v].src);
    end
    tick();
    check("idle_wr_en", wr_en, 0);

    // Collision: ALU wins, MUL waits one cycle in its slot.
    do_reset();
    set_src(WB_SRC_ALU, 5'd1, 32'h11);
    set_src(WB_SRC_MUL, 5'd2, 32'h22);
    src_valid = 4'b0101;
    expect_wr(WB_SRC_ALU, 5'd1, 32'h11);
    expect_wr(WB_SRC_MUL, 5'd2, 32'h22);
    #1;
    check("coll_ready", src_ready, 4'b1111);
    tick();
    src_valid = '0;
    check("coll_busy_held", busy, 1);
    tick();
    check("coll_mul_src", wr_src, 2);
    check("coll_busy_drained", busy, 0);
    tick();
    check("coll_idle", wr_en, 0);

    // Fairness: all sources requesting continuously for 16 cycles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < N; i++) expect_wr(i, fr_rd(i, r), fr_data(i, r));
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) set_src(i, fr_rd(i, cnt[i]), fr_data(i, cnt[i]));
      src_valid = '1;
      #1;
      acc = src_valid & src_ready;
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
    end
    #1;
    check("fair_pending", exp_q.size(), 0);
    for (int i = 0; i < N; i++) check("fair_count", wr_cnt[i], 4);

    // Back-pressure: full MUL slot loses to LSU, then drains and refills.
    do_reset();
    set_src(WB_SRC_ALU, 5'd3, 32'hA0);
    set_src(WB_SRC_LSU, 5'd4, 32'hB0);
    set_src(WB_SRC_MUL, 5'd6, 32'hC0);
    src_valid = 4'b0111;
    expect_wr(WB_SRC_ALU, 5'd3, 32'hA0);
    expect_wr(WB_SRC_LSU, 5'd4, 32'hB0);
    expect_wr(WB_SRC_MUL, 5'd6, 32'hC0);
    expect_wr(WB_SRC_MUL, 5'd7, 32'hC1);
    #1;
    check("bp_ready0", src_ready, 4'b1111);
    tick();
    src_valid = 4'b0100;
    set_src(WB_SRC_MUL, 5'd7, 32'hC1);
    #1;
    check("bp_ready_stall", src_ready, 4'b1011);
    tick();
    check("bp_busy_stall", busy, 1);
    #1;
    check("bp_ready_drain", src_ready, 4'b1111);
    tick();
    src_valid = '0;
    check("bp_busy_refill", busy, 1);
    tick();
    check("bp_busy_done", busy, 0);
    tick();
    check("bp_idle", wr_en, 0);

    // Reset with two occupied slots.
    do_reset();
    for (int i = 1; i < N; i++) set_src(i, RW'(8 + i), DW'(32'h900 + i));
    src_valid = 4'b1110;
    expect_wr(WB_SRC_LSU, 5'd9, 32'h901);
    tick();
    src_valid = '0;
    check("rst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rr_ptr", dut.u_arb.rr_ptr, 3);
    rst = 1'b0;
    tick();
    check("rst_no_write", wr_en, 0);
    for (int i = 0; i < N; i++) begin
      set_src(i, RW'(20 + i), DW'(32'h700 + i));
      expect_wr(i, RW'(20 + i), DW'(32'h700 + i));
    end
    src_valid = '1;
    #1;
    check("rst_ready_all", src_ready, 4'b1111);
    tick();
    src_valid = '0;
    check("rst_first_src", wr_src, 0);
    for (int c = 0; c < 4; c++) tick();
    #1;
    check("rst_busy_end", busy, 0);
    check("end_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
